ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-outstanding AHB-Lite initiator. Converts a simple valid/ready request port (CPU or testbench side) into AHB-Lite single transfers (NONSEQ, then IDLE).
- Returns read data and error status on a one-cycle response strobe.
- Drives the same bus our wait-stated memory slaves sit on; slave HREADYOUT connects to HREADY here.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, data-phase wait limit. Used only when the optional feature is compiled in.

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_size  in  3  HSIZE encoding for the transfer
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data; 0 on writes and on errors
- rsp_err  out  1  transfer ended in error
- HADDR  out  ADDR_W  AHB address
- HSIZE  out  3  AHB size
- HWRITE  out  1  AHB write enable
- HTRANS  out  2  AHB transfer type
- HWDATA  out  DATA_W  AHB write data
- HREADY  in  1  bus ready (slave HREADYOUT)
- HRDATA  in  DATA_W  AHB read data
- HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- One clock (HCLK); reset synchronous, active-high (HRESET).
- Reset values:
  - state IDLE.
  - HTRANS=IDLE(00); HADDR, HSIZE, HWRITE, HWDATA = 0.
  - req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
- FSM IDLE:
  - req_ready=1.
  - On req_valid, register addr/size/write/wdata and go to ADDR.
  - rsp_valid is 0 in every cycle except the one after completion.
- FSM ADDR:
  - Drive HTRANS=NONSEQ(10) with the registered HADDR/HSIZE/HWRITE; req_ready=0.
  - Hold all of these while HREADY=0.
  - At the edge with HREADY=1, go to DATA.
- FSM DATA:
  - HTRANS=IDLE(00).
  - HADDR, HSIZE, HWRITE and HWDATA stay held at the request values for the whole data phase; the slave qualifies writes and read-data gating with HWRITE during the data phase.
  - Wait while HREADY=0, including the first ERROR cycle (HRESP=1, HREADY=0).
  - At the edge with HREADY=1:
    - rsp_rdata <= (!write && !HRESP) ? HRDATA : 0.
    - rsp_err <= HRESP.
    - rsp_valid <= 1.
    - Go to IDLE and return bus outputs to 0 / HTRANS IDLE.
- Latency:
  - Accept at cycle 0; NONSEQ at cycle 1.
  - Zero-wait slave: completes at the end of cycle 2; rsp_valid in cycle 3.
  - Each slave wait cycle adds 1.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid=1 (state is IDLE). No pipelining of address over data.
- No BUSY or SEQ is ever issued. Misalignment is not checked; the slave reports it via HRESP.
- Reset mid-transfer: next edge forces IDLE and reset values. No response is issued for the aborted transfer.
- req_* inputs are ignored when req_ready=0.

Optional Feature:
- Macro AHB_MST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA and increments each DATA cycle with HREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer completes with rsp_valid=1, rsp_err=1, rsp_rdata=0 and the FSM returns to IDLE.
  - A normal HREADY=1 completion in the same cycle takes priority.
- Undefined: DATA waits indefinitely for HREADY; no counter logic is present.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t enum: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - HSIZE constants: BYTE=000, HALF=001, WORD=010.
  - HRESP constants: OKAY=0, ERROR=1.
  - Master state enum: ST_IDLE, ST_ADDR, ST_DATA.
- Optional sub-module ahb_mst_wdog, the timeout counter, instantiated only under AHB_MST_TIMEOUT_EN.

Test Plan:
- Zero-wait write, addr 0x10, data 0xDEADBEEF:
  - HTRANS=10 for one cycle, then 00.
  - HWDATA/HWRITE held until HREADY=1.
  - rsp_valid 3 cycles after accept, rsp_err=0.
- Read of 0x10 from a slave holding HREADY low 4 cycles: rsp_rdata=0xDEADBEEF, rsp_valid at cycle 7, HADDR stable throughout.
- Read of address 0x2 or out-of-range (slave returns HRESP=1): rsp_err=1, rsp_rdata=0.
- Back-to-back: req_valid held high for 3 requests. Each is accepted in its rsp_valid cycle, with no NONSEQ during a data phase.
- HRESET asserted in DATA of a 4-wait read: next cycle HTRANS=00, all outputs 0, no rsp_valid; a following request completes normally.
- With AHB_MST_TIMEOUT_EN and TIMEOUT_CYCLES=4, HREADY stuck low: rsp_valid with rsp_err=1 after 4 DATA wait cycles. Without the macro: no rsp_valid after 100 cycles.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the single-outstanding master.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } mst_state_t;

endpackage

// File: rtl/ahb_mst_wdog.sv
// Data-phase wait counter: expires on the wait cycle that brings the count to LIMIT.
// Only instantiated when AHB_MST_TIMEOUT_EN is defined.
module ahb_mst_wdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = tick && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one NONSEQ per request, then IDLE.
// Define AHB_MST_TIMEOUT_EN to bound the data phase to TIMEOUT_CYCLES wait cycles.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP,
  output logic [1:0]        state_dbg
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // rsp_valid is a single-cycle strobe with no back-pressure.
  mst_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef AHB_MST_TIMEOUT_EN
  logic to_expired;

  ahb_mst_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (HCLK),
    .rst     (HRESET),
    .clear   (state_q == ST_ADDR && HREADY),
    .tick    (state_q == ST_DATA && !HREADY),
    .expired (to_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          write_d = req_write;
          wdata_d = req_wdata;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Request registers double as bus drivers, so clearing them idles the bus.
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (!write_q && HRESP == HRESP_OKAY) ? HRDATA : '0;
          addr_d      = '0;
          size_d      = '0;
          write_d     = 1'b0;
          wdata_d     = '0;
          state_d     = ST_IDLE;
        end
`ifdef AHB_MST_TIMEOUT_EN
        else if (to_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          addr_d      = '0;
          size_d      = '0;
          write_d     = 1'b0;
          wdata_d     = '0;
          state_d     = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign HTRANS    = (state_q == ST_ADDR) ? NONSEQ : IDLE;
  assign HADDR     = addr_q;
  assign HSIZE     = size_q;
  assign HWRITE    = write_q;
  assign HWDATA    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomised scoreboard bench for ahb_lite_master with a wait-stated word memory slave.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int MODE_NORMAL  = 0;
  localparam int MODE_HANG    = 1;
  localparam int MODE_TIMEOUT = 2;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA;
  logic          HREADY, HRESP;
  logic [DW-1:0] HRDATA;
  logic [1:0]    state_dbg;

  ahb_lite_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rsp_count = 0;
  int nonseq_run = 0;
  bit chk_bus = 1'b1;

  logic [64:0] exp_q[$];   // {rsp cycle, err, rdata}
  int          wait_q[$];
  logic [31:0] ref_mem [16];

  logic [AW-1:0] cur_addr;
  logic          cur_write;
  logic [DW-1:0] cur_wdata;
  int unsigned   acc_cyc;
  int unsigned   last_exp_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h40);
  endfunction

  // ---------------- slave model ----------------
  logic [31:0] slv_mem [16];
  bit          dphase = 1'b0;
  bit          slv_stuck = 1'b0;
  logic [31:0] d_addr;
  bit          d_write, d_err, err_stage;
  int          d_wait;

  initial begin
    logic       s_rst, s_rdy, s_write;
    logic [1:0] s_trans;
    logic [31:0] s_addr, s_wdata;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(posedge HCLK);
      s_rst = HRESET; s_trans = HTRANS; s_rdy = HREADY;
      s_addr = HADDR; s_write = HWRITE; s_wdata = HWDATA;
      if (s_rst) begin
        dphase = 1'b0;
      end else begin
        if (dphase && s_rdy) begin
          if (d_write && !d_err) slv_mem[d_addr[5:2]] = s_wdata;
          dphase = 1'b0;
        end
        if (s_trans == 2'b10 && s_rdy) begin
          dphase = 1'b1; d_addr = s_addr; d_write = s_write;
          d_err = is_err(s_addr); err_stage = 1'b0;
          d_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
      end
      #1;
      HRDATA = $urandom;
      if (dphase) begin
        if (slv_stuck) begin
          HREADY = 1'b0; HRESP = 1'b0;
        end else if (d_wait > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; d_wait--;
        end else if (d_err) begin
          HRESP = 1'b1; HREADY = err_stage; err_stage = 1'b1;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
          if (!d_write) HRDATA = slv_mem[d_addr[5:2]];
        end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge HCLK) begin
    if (!HRESET && chk_bus) begin
      if (HTRANS == 2'b10) begin
        nonseq_run++;
        check("nonseq_haddr", HADDR, cur_addr);
        check("nonseq_outside_dphase", dphase, 0);
        check("nonseq_hsize", HSIZE, HSIZE_WORD);
      end else if (dphase) begin
        check("dphase_htrans", HTRANS, 0);
        check("dphase_haddr", HADDR, cur_addr);
        check("dphase_hwrite", HWRITE, cur_write);
        if (cur_write) check("dphase_hwdata", HWDATA, cur_wdata);
      end else begin
        check("idle_haddr", HADDR, 0);
        check("idle_ctrl", {HWRITE, HSIZE, HTRANS}, 0);
        check("idle_hwdata", HWDATA, 0);
      end
    end
  end

  always @(negedge HCLK) begin
    logic [64:0] e;
    if (!HRESET && rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 err=%0b rdata=0x%0h expected no response (cycle %0d)",
                 rsp_err, rsp_rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", rsp_err, e[32]);
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_cycle", cyc, e[64:33]);
        check("nonseq_cycles", nonseq_run, 1);
        nonseq_run = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input int mode);
    logic        err;
    logic [31:0] rd, ec;
    int          lat;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = HSIZE_WORD; req_wdata = d;
    for (int k = 0; k < 300 && !req_ready; k++) @(negedge HCLK);
    check("req_accept", req_ready, 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    err = is_err(a);
    rd  = '0;
    if (mode == MODE_TIMEOUT) begin
      err = 1'b1;
      lat = 2 + TO;
    end else begin
      if (!w && !err) rd = ref_mem[a[5:2]];
      if (w && !err) ref_mem[a[5:2]] = d;
      lat = 3 + waits + (err ? 1 : 0);
    end
    acc_cyc = cyc;
    ec = acc_cyc + lat;
    if (mode != MODE_HANG) exp_q.push_back({ec, err, rd});
    last_exp_cyc = ec;
    wait_q.push_back(waits);
    cur_addr = a; cur_write = w; cur_wdata = d;
    @(posedge HCLK);
    @(negedge HCLK);
    req_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_htrans"}, HTRANS, 0);
    check({tag, "_haddr"}, HADDR, 0);
    check({tag, "_hsize_hwrite"}, {HSIZE, HWRITE}, 0);
    check({tag, "_hwdata"}, HWDATA, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          rc;
    int unsigned prev_exp;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    cur_addr = '0; cur_write = 1'b0; cur_wdata = '0;
    repeat (3) @(negedge HCLK);
    check_reset_vals("reset");
    HRESET = 1'b0;
    @(negedge HCLK);

    // directed: zero-wait write, wait-stated read, error reads
    issue(1'b1, 32'h10, 32'hDEADBEEF, 0, MODE_NORMAL);
    issue(1'b0, 32'h10, 32'h0, 4, MODE_NORMAL);
    issue(1'b0, 32'h2, 32'h0, 1, MODE_NORMAL);
    issue(1'b0, 32'h80, 32'h0, 0, MODE_NORMAL);
    repeat (10) @(negedge HCLK);

    // back-to-back: each accepted in the previous response cycle
    issue(1'b1, 32'h20, 32'h12345678, 1, MODE_NORMAL);
    prev_exp = last_exp_cyc;
    issue(1'b0, 32'h20, 32'h0, 0, MODE_NORMAL);
    check("b2b_accept_1", acc_cyc, prev_exp);
    prev_exp = last_exp_cyc;
    issue(1'b0, 32'h10, 32'h0, 2, MODE_NORMAL);
    check("b2b_accept_2", acc_cyc, prev_exp);
    repeat (10) @(negedge HCLK);

    // reset during the data phase of a 4-wait read
    issue(1'b0, 32'h10, 32'h0, 4, MODE_NORMAL);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b1;
    exp_q.delete(); wait_q.delete();
    @(negedge HCLK);
    check_reset_vals("abort");
    HRESET = 1'b0; nonseq_run = 0;
    rc = rsp_count;
    repeat (8) @(negedge HCLK);
    check("abort_no_rsp", rsp_count, rc);
    issue(1'b0, 32'h20, 32'h0, 1, MODE_NORMAL);
    repeat (8) @(negedge HCLK);

    // slave stuck with HREADY low
    chk_bus = 1'b0; slv_stuck = 1'b1; rc = rsp_count;
`ifdef AHB_MST_TIMEOUT_EN
    issue(1'b0, 32'h14, 32'h0, 0, MODE_TIMEOUT);
    repeat (TO + 6) @(negedge HCLK);
    check("timeout_rsp_count", rsp_count, rc + 1);
`else
    issue(1'b0, 32'h14, 32'h0, 0, MODE_HANG);
    repeat (100) @(negedge HCLK);
    check("hang_no_rsp", rsp_count, rc);
    check("hang_state_data", state_dbg, 2);
`endif
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0; slv_stuck = 1'b0;
    exp_q.delete(); wait_q.delete(); nonseq_run = 0;
    @(negedge HCLK);
    chk_bus = 1'b1;

    // randomised traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'h40 + (32'($urandom_range(0, 63)) << 2);
      issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), MODE_NORMAL);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge HCLK);
    end

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge HCLK);
    check("drain_exp_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
